// File: rtl/instruction_fetch_unit_pkg.sv
// Shared CPU definitions for the fetch front end: FSM encoding and reset vector.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_I = 2'd0,
    FETCH_O = 2'd1,
    PRESENT = 2'd2
  } ifu_state_e;

  localparam logic [15:0] IFU_RESET_PC = 16'h0000;

endpackage

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch FSM: fetches an instruction word, optionally its attached
// operand word, and presents the pair to execute with a valid/ready handshake.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = IFU_RESET_PC,
  parameter int          ATTACH_BIT = 1
) (
  input  logic        clock,
  input  logic        reset,
  output logic [15:0] mem_addr,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [15:0] mem_data,
  input  logic        jump,
  input  logic [15:0] jump_addr,
  output logic [15:0] instr,
  output logic [15:0] operand,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [15:0] pc
);

  ifu_state_e  state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] operand_q, operand_d;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH_I;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      operand_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      operand_q <= operand_d;
    end
  end

  // A jump always wins over a same-cycle ack: the fetched word is dropped.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    operand_d = operand_q;
    case (state_q)
      FETCH_I: begin
        if (jump) begin
          pc_d    = jump_addr;
          state_d = FETCH_I;
        end else if (mem_ack) begin
          instr_d = mem_data;
          pc_d    = pc_inc;
          if (mem_data[ATTACH_BIT]) begin
            state_d = FETCH_O;
          end else begin
            operand_d = '0;
            state_d   = PRESENT;
          end
        end
      end
      FETCH_O: begin
        if (jump) begin
          pc_d    = jump_addr;
          state_d = FETCH_I;
        end else if (mem_ack) begin
          operand_d = mem_data;
          pc_d      = pc_inc;
          state_d   = PRESENT;
        end
      end
      PRESENT: begin
        if (jump) begin
          pc_d    = jump_addr;
          state_d = FETCH_I;
        end else if (instr_ready) begin
          state_d = FETCH_I;
        end
      end
      default: begin
        state_d = FETCH_I;
      end
    endcase
  end

  // Request is gated by reset directly so it drops mid-transaction at once.
  assign mem_req     = ~reset & (state_q != PRESENT);
  assign mem_addr    = pc_q;
  assign instr_valid = (state_q == PRESENT);
  assign instr       = instr_q;
  assign operand     = operand_q;
  assign pc          = pc_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: table of straight-line fetches
// followed by hand sequences for jumps, pc wrap and mid-transaction reset.
module tb_instruction_fetch_unit;

  logic        clock;
  logic        reset;
  logic [15:0] mem_addr;
  logic        mem_req;
  logic        mem_ack;
  logic [15:0] mem_data;
  logic        jump;
  logic [15:0] jump_addr;
  logic [15:0] instr;
  logic [15:0] operand;
  logic        instr_valid;
  logic        instr_ready;
  logic [15:0] pc;

  instruction_fetch_unit #(
    .RESET_PC  (16'h0000),
    .ATTACH_BIT(1)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .mem_addr   (mem_addr),
    .mem_req    (mem_req),
    .mem_ack    (mem_ack),
    .mem_data   (mem_data),
    .jump       (jump),
    .jump_addr  (jump_addr),
    .instr      (instr),
    .operand    (operand),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .pc         (pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] mem [0:65535];
  int          ack_delay = 0;
  int          ack_cnt   = 0;

  // Memory responder: acks a request ack_delay cycles after it is first seen.
  always @(posedge clock) begin
    #1;
    if (reset) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      ack_cnt = 0;
    end else if (mem_req) begin
      if (ack_cnt >= ack_delay) begin
        mem_ack  = 1'b1;
        mem_data = mem[mem_addr];
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (instr_valid !== 1'b1 && k < 60) begin
      @(negedge clock);
      k++;
    end
    n_vec++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s: instr_valid never rose within %0d cycles", name, k);
    end
  endtask

  typedef struct {
    int          ack_dly;
    int          hold;
    logic [15:0] exp_instr;
    logic [15:0] exp_operand;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs [5];

  initial begin
    vecs[0] = '{2, 0,  16'h1000, 16'h0000, 16'h0001};
    vecs[1] = '{0, 10, 16'h2002, 16'hBEEF, 16'h0003};
    vecs[2] = '{1, 0,  16'h0004, 16'h0000, 16'h0004};
    vecs[3] = '{3, 2,  16'h0003, 16'h1234, 16'h0006};
    vecs[4] = '{0, 0,  16'hFFFD, 16'h0000, 16'h0007};

    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    mem[16'h0000] = 16'h1000;
    mem[16'h0001] = 16'h2002;
    mem[16'h0002] = 16'hBEEF;
    mem[16'h0003] = 16'h0004;
    mem[16'h0004] = 16'h0003;
    mem[16'h0005] = 16'h1234;
    mem[16'h0006] = 16'hFFFD;
    mem[16'h0007] = 16'h0002;
    mem[16'h0008] = 16'h5555;
    mem[16'h0040] = 16'h00A1;
    mem[16'hFFFF] = 16'h0010;

    reset       = 1'b0;
    jump        = 1'b0;
    jump_addr   = 16'h0000;
    instr_ready = 1'b0;
    mem_ack     = 1'b0;
    mem_data    = 16'h0000;
    #1 reset = 1'b1;
    #1;
    chk("reset_mem_req", {15'd0, mem_req}, 16'd0);
    chk("reset_valid", {15'd0, instr_valid}, 16'd0);
    chk("reset_pc", pc, 16'h0000);
    chk("reset_instr", instr, 16'h0000);
    chk("reset_operand", operand, 16'h0000);

    ack_delay = vecs[0].ack_dly;
    repeat (2) @(negedge clock);
    chk("reset_held_mem_req", {15'd0, mem_req}, 16'd0);
    reset = 1'b0;
    #1;
    chk("first_req", {15'd0, mem_req}, 16'd1);
    chk("first_addr", mem_addr, 16'h0000);

    for (int i = 0; i < 5; i++) begin
      wait_valid($sformatf("vec%0d_wait", i));
      chk($sformatf("vec%0d_instr", i), instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_operand", i), operand, vecs[i].exp_operand);
      chk($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("vec%0d_req", i), {15'd0, mem_req}, 16'd0);
      for (int h = 0; h < vecs[i].hold; h++) begin
        @(negedge clock);
        chk($sformatf("vec%0d_hold_instr", i), instr, vecs[i].exp_instr);
        chk($sformatf("vec%0d_hold_operand", i), operand, vecs[i].exp_operand);
        chk($sformatf("vec%0d_hold_req", i), {15'd0, mem_req}, 16'd0);
        chk($sformatf("vec%0d_hold_valid", i), {15'd0, instr_valid}, 16'd1);
      end
      ack_delay   = (i < 4) ? vecs[i+1].ack_dly : 1;
      instr_ready = 1'b1;
      @(negedge clock);
      instr_ready = 1'b0;
      chk($sformatf("vec%0d_bubble", i), {15'd0, instr_valid}, 16'd0);
    end

    // Jump coincident with the operand ack: operand must not load.
    begin
      int k;
      k = 0;
      while (!(mem_req && mem_ack && mem_addr == 16'h0008) && k < 40) begin
        @(negedge clock);
        k++;
      end
      chk("fetch_o_ack_seen", {15'd0, (mem_req && mem_ack && mem_addr == 16'h0008)}, 16'd1);
    end
    jump      = 1'b1;
    jump_addr = 16'h0040;
    @(negedge clock);
    jump = 1'b0;
    chk("jack_operand", operand, 16'h0000);
    chk("jack_addr", mem_addr, 16'h0040);
    chk("jack_req", {15'd0, mem_req}, 16'd1);
    chk("jack_valid", {15'd0, instr_valid}, 16'd0);
    wait_valid("jack_wait");
    chk("jack_instr", instr, 16'h00A1);
    chk("jack_pc", pc, 16'h0041);

    // Jump during a pending instruction fetch redirects the request.
    ack_delay   = 3;
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    chk("jpend_req", {15'd0, mem_req}, 16'd1);
    chk("jpend_old_addr", mem_addr, 16'h0041);
    jump      = 1'b1;
    jump_addr = 16'hFFFF;
    @(negedge clock);
    jump = 1'b0;
    chk("jpend_new_addr", mem_addr, 16'hFFFF);
    chk("jpend_req2", {15'd0, mem_req}, 16'd1);
    wait_valid("wrap_wait");
    chk("wrap_instr", instr, 16'h0010);
    chk("wrap_pc", pc, 16'h0000);
    ack_delay   = 0;
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    chk("wrap_next_addr", mem_addr, 16'h0000);
    chk("wrap_next_req", {15'd0, mem_req}, 16'd1);

    // Jump in PRESENT together with ready.
    wait_valid("jp_wait");
    chk("jp_instr", instr, 16'h1000);
    jump        = 1'b1;
    jump_addr   = 16'h0004;
    instr_ready = 1'b1;
    @(negedge clock);
    jump        = 1'b0;
    instr_ready = 1'b0;
    chk("jp_valid", {15'd0, instr_valid}, 16'd0);
    chk("jp_pc", pc, 16'h0004);
    chk("jp_req", {15'd0, mem_req}, 16'd1);
    wait_valid("jp_fetch_wait");
    chk("jp_instr2", instr, 16'h0003);
    chk("jp_operand2", operand, 16'h1234);
    chk("jp_pc2", pc, 16'h0006);

    // Reset asserted mid-transaction, away from any clock edge.
    ack_delay   = 3;
    instr_ready = 1'b1;
    @(negedge clock);
    instr_ready = 1'b0;
    @(posedge clock);
    #3;
    chk("mrst_pre_req", {15'd0, mem_req}, 16'd1);
    reset = 1'b1;
    #1;
    chk("mrst_req", {15'd0, mem_req}, 16'd0);
    chk("mrst_valid", {15'd0, instr_valid}, 16'd0);
    chk("mrst_pc", pc, 16'h0000);
    chk("mrst_operand", operand, 16'h0000);
    ack_delay = 1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("mrst_restart_req", {15'd0, mem_req}, 16'd1);
    chk("mrst_restart_addr", mem_addr, 16'h0000);
    wait_valid("mrst_wait");
    chk("mrst_instr", instr, 16'h1000);
    chk("mrst_pc2", pc, 16'h0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000: program counter value loaded on reset.
REQ-002 Parameter ATTACH_BIT, default 1: instruction bit index that flags an attached operand word.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 mem_addr  output  16  fetch word address.
REQ-006 mem_req  output  1  fetch request; held high until acknowledged.
REQ-007 mem_ack  input  1  memory acknowledge; mem_data valid in the same cycle.
REQ-008 mem_data  input  16  fetched word.
REQ-009 jump  input  1  one-cycle pulse: redirect fetch to jump_addr.
REQ-010 jump_addr  input  16  jump target.
REQ-011 instr  output  16  instruction word presented to the execution stage.
REQ-012 operand  output  16  attached operand word; 0 when none is attached.
REQ-013 instr_valid  output  1  instr/operand are valid.
REQ-014 instr_ready  input  1  execution stage accepts the instruction.
REQ-015 pc  output  16  address of the next word to fetch.

Function
REQ-016 FSM states SHALL be FETCH_I, FETCH_O and PRESENT.
REQ-017 FETCH_I SHALL drive mem_req=1 with mem_addr=pc; on mem_ack it SHALL load instr=mem_data and set pc=pc+1.
REQ-018 After FETCH_I completes, the FSM SHALL go to FETCH_O if mem_data[ATTACH_BIT]=1, else clear operand and go to PRESENT.
REQ-019 FETCH_O SHALL drive mem_req=1 with mem_addr=pc; on mem_ack it SHALL load operand=mem_data, set pc=pc+1 and go to PRESENT.
REQ-020 mem_addr SHALL remain stable while mem_req=1 and mem_ack=0.
REQ-021 PRESENT SHALL drive instr_valid=1 with instr and operand held stable until instr_valid and instr_ready are both high.
REQ-022 On transfer in PRESENT, instr_valid SHALL drop the next cycle and the FSM SHALL enter FETCH_I, giving one bubble per instruction.
REQ-023 mem_req SHALL be 0 in PRESENT; instr_valid SHALL be 0 in FETCH_I and FETCH_O.
REQ-024 pc SHALL wrap from 16'hFFFF to 16'h0000 without error.
REQ-025 jump in PRESENT SHALL set pc=jump_addr, drop instr_valid and enter FETCH_I; a simultaneous instr_ready counts as a transfer.
REQ-026 jump in FETCH_I or FETCH_O with no mem_ack that cycle SHALL set pc=jump_addr and enter FETCH_I; the pending request continues at the new address.
REQ-027 jump coincident with mem_ack SHALL discard mem_data, set pc=jump_addr and enter FETCH_I.
REQ-028 Once in PRESENT, mem_ack SHALL be ignored.

Reset
REQ-029 On reset assertion, without waiting for a clock edge, the block SHALL set: state=FETCH_I, pc=RESET_PC, instr=0, operand=0, instr_valid=0.
REQ-030 mem_req SHALL be 0 while reset is high, including mid-transaction; the first request SHALL issue in the first cycle after deassertion, at RESET_PC.

Structure
REQ-031 The FSM state encoding and the RESET_PC default SHALL reside in the shared cpu package.
REQ-032 The block SHALL be a single module with no sub-modules; the pc incrementer SHALL be inline.

Verification
REQ-033 Reset, memory 0x0000=16'h1000, ack after 2 cycles -> instr=16'h1000, operand=0, instr_valid=1, pc=0x0001.
REQ-034 Word 0x0001=16'h2002 (bit1 set), 0x0002=16'hBEEF -> instr=16'h2002, operand=16'hBEEF, pc=0x0003.
REQ-035 instr_ready held low for 10 cycles in PRESENT -> instr and operand stable; mem_req=0 throughout.
REQ-036 jump to 0x0040 coincident with mem_ack in FETCH_O -> operand not loaded; next mem_addr=0x0040.
REQ-037 pc=16'hFFFF, non-attached word fetched -> pc=16'h0000; next mem_addr=16'h0000.
REQ-038 reset asserted while mem_req=1 -> mem_req=0 and instr_valid=0 immediately; restart at RESET_PC.
